// File: rtl/cable_serial_rx.sv
// cable_serial_rx: 8N1 serial receiver with a one-entry valid/ready output register
module cable_serial_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0] sync;
  logic rx_s;
  logic [TW-1:0] timer, timer_d;
  logic [2:0] idx, idx_d;
  logic [7:0] shift, shift_d;
  logic stop_ok, ferr, load;
  assign rx_s = sync[SYNC_STAGES-1];
  assign busy = state != IDLE;
  assign load = stop_ok && (!rx_valid || rx_ready);
  // state, counters, synchronizer and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= '1;
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], rx_in};
      state     <= state_d;
      timer     <= timer_d;
      idx       <= idx_d;
      shift     <= shift_d;
      rx_data   <= load ? shift : rx_data;
      rx_valid  <= load || (rx_valid && !rx_ready);
      frame_err <= ferr;
      overrun   <= stop_ok && !load;
    end
  end
  // next state: mid-bit sampling driven by the bit timer
  always_comb begin
    state_d = state;
    timer_d = timer + 1'b1;
    idx_d   = idx;
    shift_d = shift;
    stop_ok = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: begin
        timer_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (timer == HALF) begin
        timer_d = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (timer == FULL) begin
        timer_d = '0;
        shift_d = {rx_s, shift[7:1]};
        idx_d   = idx + 3'd1;
        state_d = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (timer == FULL) begin
        timer_d = '0;
        stop_ok = rx_s;
        ferr    = !rx_s;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        timer_d = '0;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_cable_serial_rx.sv
// tb_cable_serial_rx: scenario tasks with a byte scoreboard for cable_serial_rx
`timescale 1ns/1ps
module tb_cable_serial_rx;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_in = 1'b1;
  logic rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rcv_q[$];

  cable_serial_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // observe accepted bytes and error pulses away from the active edge
  always @(negedge clk) begin
    if (rx_valid && rx_ready) rcv_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit push);
    if (push) exp_q.push_back(b);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    rx_in = stop;
    tick(CPB);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    tick(1);
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_single;
    int t0;
    rx_ready = 1'b0;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    tick(30);
    @(negedge clk);
    checks++; if (rise_cyc - t0 < 152 || rise_cyc - t0 > 158) begin errors++; $display("FAIL latency got %0d exp 152..158", rise_cyc - t0); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL hold_data got %h exp a5", rx_data); end
    checks++; if (rcv_q.size() != 0) begin errors++; $display("FAIL early_accept got %0d exp 0", rcv_q.size()); end
    tick(1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %b exp 0", rx_valid); end
    checks++; if (rcv_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count got %0d exp %0d", rcv_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front(); g = rcv_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL single_data got %h exp %h", g, e); end
    end
    exp_q.delete(); rcv_q.delete();
    tick(5);
  endtask

  task automatic test_back_to_back;
    int f0, o0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx_ready = 1'b1;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    tick(20);
    checks++; if (rcv_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", rcv_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front(); g = rcv_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_data got %h exp %h", g, e); end
    end
    exp_q.delete(); rcv_q.delete();
    checks++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin errors++; $display("FAIL b2b_pulses got ferr=%0d ovr=%0d exp 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_glitch;
    int f0, o0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx_ready = 1'b1;
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    tick(40);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
    checks++; if (rx_valid !== 1'b0 || rcv_q.size() != 0) begin errors++; $display("FAIL glitch_valid got %b/%0d exp 0/0", rx_valid, rcv_q.size()); end
    checks++; if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin errors++; $display("FAIL glitch_pulses got ferr=%0d ovr=%0d exp 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    rcv_q.delete();
  endtask

  task automatic test_frame_err;
    int f0;
    f0 = ferr_cnt;
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(30);
    @(negedge clk);
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulses got %0d exp 1", ferr_cnt - f0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy got %b exp 1", busy); end
    checks++; if (rx_valid !== 1'b0 || rcv_q.size() != 0) begin errors++; $display("FAIL ferr_valid got %b/%0d exp 0/0", rx_valid, rcv_q.size()); end
    tick(10);
    rx_in = 1'b1;
    tick(8);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_idle got %b exp 0", busy); end
    tick(8);
    send_frame(8'h5A, 1'b1, 1'b1);
    tick(10);
    checks++; if (rcv_q.size() != exp_q.size()) begin errors++; $display("FAIL ferr_next_count got %0d exp %0d", rcv_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front(); g = rcv_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL ferr_next_data got %h exp %h", g, e); end
    end
    exp_q.delete(); rcv_q.delete();
  endtask

  task automatic test_overrun;
    int o0;
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(10);
    @(negedge clk);
    checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt - o0); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ovr_hold got %b/%h exp 1/11", rx_valid, rx_data); end
    tick(1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    checks++; if (rcv_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_count got %0d exp %0d", rcv_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front(); g = rcv_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL ovr_data got %h exp %h", g, e); end
    end
    exp_q.delete(); rcv_q.delete();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", rx_valid); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    b = 8'h6D;
    rx_ready = 1'b0;
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(4);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    rx_in = b[4];
    tick(CPB / 2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_state got busy=%b valid=%b exp 0 0", busy, rx_valid); end
    checks++; if (rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rmid_out got %h/%b/%b exp 00/0/0", rx_data, frame_err, overrun); end
    rx_in = 1'b1;
    tick(40);
    rx_ready = 1'b1;
    send_frame(8'h96, 1'b1, 1'b1);
    tick(10);
    checks++; if (rcv_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count got %0d exp %0d", rcv_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front(); g = rcv_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rmid_data got %h exp %h", g, e); end
    end
    exp_q.delete(); rcv_q.delete();
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
